// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: synchronises SCLK/SS_n/MOSI into i_clk, shifts words in on MOSI and
// out on MISO from a single-entry transmit buffer, with back-to-back words per SS_n assertion.
module spi_slave_core #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sclk,
   input  logic                  i_ss_n,
   input  logic                  i_mosi,
   output logic                  o_miso,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_tx_underrun,
   output logic                  o_busy
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic {StIdle, StActive} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
   logic                   r_sclk_d, r_ss_d;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_reload;
   logic [DATA_WIDTH-1:0]  r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
   logic                   r_tx_full, r_miso, r_rx_valid, r_tx_underrun, r_busy;

   logic w_sclk, w_ss_n, w_mosi;
   logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
   logic w_word_done, w_tx_write, w_load, w_tx_shift;

   // Pin synchronisers plus one extra stage on sclk/ss_n for edge detection.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sclk_sync <= '0;
         r_ss_sync   <= '1;
         r_mosi_sync <= '1;
         r_sclk_d    <= 1'b0;
         r_ss_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_ss_n      = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_ss_fall   = ~w_ss_n & r_ss_d;
   assign w_ss_rise   = w_ss_n & ~r_ss_d;

   assign w_word_done = (r_cnt == CNT_W'(DATA_WIDTH));
   assign w_tx_write  = i_tx_valid & ~r_tx_full;

   // Loads happen on frame start, or on the first falling edge after a completed word.
   always_comb begin
      w_load     = 1'b0;
      w_tx_shift = 1'b0;
      if (r_state == StIdle) begin
         w_load = w_ss_fall;
      end else if (!w_ss_rise && !w_word_done && !w_sclk_rise && w_sclk_fall) begin
         w_load     = r_reload;
         w_tx_shift = ~r_reload;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_reload      <= 1'b0;
         r_tx_buf      <= '1;
         r_tx_full     <= 1'b0;
         r_tx_shift    <= '1;
         r_rx_shift    <= '1;
         r_rx_data     <= '1;
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_miso        <= 1'b1;
         r_busy        <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;

         // A load in the same cycle as a write sees the buffer empty; the write wins.
         if (w_tx_write) begin
            r_tx_buf  <= i_tx_data;
            r_tx_full <= 1'b1;
         end else if (w_load) begin
            r_tx_full <= 1'b0;
         end

         if (w_load) begin
            r_tx_shift    <= r_tx_full ? r_tx_buf : '1;
            r_tx_underrun <= ~r_tx_full;
         end else if (w_tx_shift) begin
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b1};
         end

         unique case (r_state)
            StIdle: begin
               r_miso <= 1'b1;
               if (w_ss_fall) begin
                  r_state  <= StActive;
                  r_cnt    <= '0;
                  r_reload <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            StActive: begin
               r_miso <= r_tx_shift[DATA_WIDTH-1];
               if (w_ss_rise) begin
                  r_state  <= StIdle;
                  r_cnt    <= '0;
                  r_reload <= 1'b0;
                  r_busy   <= 1'b0;
                  r_miso   <= 1'b1;
               end else if (w_word_done) begin
                  r_rx_data  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
                  r_cnt      <= '0;
                  r_reload   <= 1'b1;
               end else if (w_sclk_rise) begin
                  r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                  r_cnt      <= r_cnt + CNT_W'(1);
               end else if (w_sclk_fall && r_reload) begin
                  r_reload <= 1'b0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_miso        = r_miso;
   assign o_tx_ready    = ~r_tx_full;
   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;
   assign o_tx_underrun = r_tx_underrun;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: drives SPI mode-0 frames and checks MISO, RX and TX status.
module tb_spi_slave_core;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b1;
   logic       miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int rx_cnt   = 0;
   int urun_cnt = 0;
   logic [7:0] rx_q[$];

   spi_slave_core #(
      .DATA_WIDTH (8),
      .SYNC_STAGES(2)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst_n),
      .i_sclk       (sclk),
      .i_ss_n       (ss_n),
      .i_mosi       (mosi),
      .o_miso       (miso),
      .i_tx_data    (tx_data),
      .i_tx_valid   (tx_valid),
      .o_tx_ready   (tx_ready),
      .o_rx_data    (rx_data),
      .o_rx_valid   (rx_valid),
      .o_tx_underrun(tx_underrun),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         rx_q.push_back(rx_data);
      end
      if (tx_underrun) urun_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [7:0] d);
      int n = 0;
      while (!tx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_write_ready: got %b want 1", tx_ready);
      end
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Sends nbits of mo MSB first; sclk is left high after the final rise.
   task automatic spi_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = mo[7-i];
         wait_cyc(HALF);
         mi[7-i] = miso;
         sclk = 1'b1;
         wait_cyc(HALF);
      end
   endtask

   task automatic frame_start();
      ss_n = 1'b0;
      wait_cyc(HALF);
   endtask

   task automatic frame_end();
      ss_n = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
      wait_cyc(HALF);
   endtask

   task automatic test_reset();
      n_checks++;
      if (miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", miso); end
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      n_checks++;
      if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL reset_rx_data: got %h want ff", rx_data); end
      n_checks++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_checks++;
      if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] mi;
      int r0 = rx_cnt;
      int u0 = urun_cnt;
      tx_write(8'hA5);
      n_checks++;
      if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full: got %b want 0", tx_ready); end
      frame_start();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_load: got %b want 1", tx_ready); end
      spi_word(8'h3C, 8, mi);
      n_checks++;
      if (mi !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %h want a5", mi); end
      frame_end();
      n_checks++;
      if (rx_cnt - r0 !== 1) begin n_fail++; $display("FAIL basic_rx_pulses: got %0d want 1", rx_cnt - r0); end
      n_checks++;
      if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data: got %h want 3c", rx_data); end
      n_checks++;
      if (urun_cnt - u0 !== 0) begin n_fail++; $display("FAIL basic_underrun: got %0d want 0", urun_cnt - u0); end
      n_checks++;
      if (busy !== 1'b0 || miso !== 1'b1) begin
         n_fail++; $display("FAIL basic_idle: got busy=%b miso=%b want busy=0 miso=1", busy, miso);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi0, mi1;
      int r0 = rx_cnt;
      int u0 = urun_cnt;
      tx_write(8'h81);
      ss_n = 1'b0;
      wait_cyc(6);
      tx_write(8'h7E);
      spi_word(8'hF0, 8, mi0);
      spi_word(8'h0F, 8, mi1);
      frame_end();
      n_checks++;
      if (mi0 !== 8'h81) begin n_fail++; $display("FAIL b2b_miso0: got %h want 81", mi0); end
      n_checks++;
      if (mi1 !== 8'h7E) begin n_fail++; $display("FAIL b2b_miso1: got %h want 7e", mi1); end
      n_checks++;
      if (rx_cnt - r0 !== 2) begin n_fail++; $display("FAIL b2b_rx_pulses: got %0d want 2", rx_cnt - r0); end
      n_checks++;
      if (rx_q.size() < 2 || rx_q[rx_q.size()-2] !== 8'hF0 || rx_q[rx_q.size()-1] !== 8'h0F) begin
         n_fail++;
         $display("FAIL b2b_rx_words: got %p want f0,0f", rx_q);
      end
      n_checks++;
      if (urun_cnt - u0 !== 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 0", urun_cnt - u0); end
   endtask

   task automatic test_underrun();
      logic [7:0] mi;
      int r0 = rx_cnt;
      int u0 = urun_cnt;
      frame_start();
      spi_word(8'h5A, 8, mi);
      frame_end();
      n_checks++;
      if (urun_cnt - u0 !== 1) begin n_fail++; $display("FAIL urun_pulses: got %0d want 1", urun_cnt - u0); end
      n_checks++;
      if (mi !== 8'hFF) begin n_fail++; $display("FAIL urun_miso: got %h want ff", mi); end
      n_checks++;
      if (rx_cnt - r0 !== 1 || rx_data !== 8'h5A) begin
         n_fail++; $display("FAIL urun_rx: got %0d pulses data %h want 1 pulse data 5a", rx_cnt - r0, rx_data);
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      int r0 = rx_cnt;
      frame_start();
      spi_word(8'h00, 5, mi);
      frame_end();
      n_checks++;
      if (rx_cnt - r0 !== 0) begin n_fail++; $display("FAIL abort_rx_pulses: got %0d want 0", rx_cnt - r0); end
      n_checks++;
      if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL abort_rx_held: got %h want 5a", rx_data); end
      n_checks++;
      if (busy !== 1'b0 || miso !== 1'b1) begin
         n_fail++; $display("FAIL abort_idle: got busy=%b miso=%b want busy=0 miso=1", busy, miso);
      end
      tx_write(8'h3A);
      frame_start();
      spi_word(8'hC3, 8, mi);
      frame_end();
      n_checks++;
      if (mi !== 8'h3A) begin n_fail++; $display("FAIL abort_next_miso: got %h want 3a", mi); end
      n_checks++;
      if (rx_cnt - r0 !== 1 || rx_data !== 8'hC3) begin
         n_fail++; $display("FAIL abort_next_rx: got %0d pulses data %h want 1 pulse data c3", rx_cnt - r0, rx_data);
      end
   endtask

   task automatic test_coincident_write();
      logic [7:0] mi0, mi1;
      int r0 = rx_cnt;
      int u0 = urun_cnt;
      ss_n = 1'b0;
      wait_cyc(2);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      wait_cyc(1);
      tx_valid = 1'b0;
      n_checks++;
      if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL coinc_captured: got ready=%b want 0", tx_ready); end
      spi_word(8'h12, 8, mi0);
      spi_word(8'h34, 8, mi1);
      frame_end();
      n_checks++;
      if (urun_cnt - u0 !== 1) begin n_fail++; $display("FAIL coinc_underrun: got %0d want 1", urun_cnt - u0); end
      n_checks++;
      if (mi0 !== 8'hFF) begin n_fail++; $display("FAIL coinc_miso0: got %h want ff", mi0); end
      n_checks++;
      if (mi1 !== 8'h55) begin n_fail++; $display("FAIL coinc_miso1: got %h want 55", mi1); end
      n_checks++;
      if (rx_cnt - r0 !== 2 || rx_q[rx_q.size()-2] !== 8'h12 || rx_q[rx_q.size()-1] !== 8'h34) begin
         n_fail++; $display("FAIL coinc_rx: got %0d pulses %p want 12,34", rx_cnt - r0, rx_q);
      end
   endtask

   task automatic test_reset_mid_active();
      logic [7:0] mi;
      int r0;
      tx_write(8'hE7);
      frame_start();
      spi_word(8'hAA, 3, mi);
      rst_n = 1'b0;
      ss_n  = 1'b1;
      sclk  = 1'b0;
      #1;
      test_reset();
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", tx_ready); end
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(4);
      r0 = rx_cnt;
      tx_write(8'h96);
      frame_start();
      spi_word(8'h69, 8, mi);
      frame_end();
      n_checks++;
      if (mi !== 8'h96) begin n_fail++; $display("FAIL rst_mid_miso: got %h want 96", mi); end
      n_checks++;
      if (rx_cnt - r0 !== 1 || rx_data !== 8'h69) begin
         n_fail++; $display("FAIL rst_mid_rx: got %0d pulses data %h want 1 pulse data 69", rx_cnt - r0, rx_data);
      end
   endtask

   initial begin
      wait_cyc(3);
      test_reset();
      rst_n = 1'b1;
      wait_cyc(4);
      test_basic();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_coincident_write();
      test_reset_mid_active();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the SPI project. It synchronises the external SCLK, SS_n and MOSI pins into the system clock domain and shifts received bits into a parallel word, while shifting a buffered transmit word out on MISO. It pairs with the master-side shift-register datapath at the other end of the link. It supports back-to-back words within one SS_n assertion and presents a valid/ready transmit interface and a single-cycle receive strobe to local logic.

## Interface
- DATA_WIDTH, 8, bits per SPI word (≥2)
- SYNC_STAGES, 2, synchroniser depth on SCLK/SS_n/MOSI (≥2)

- i_clk  input  1  system clock; all state on rising edge
- i_rst  input  1  asynchronous active-low reset
- i_sclk  input  1  SPI clock pin (asynchronous)
- i_ss_n  input  1  SPI slave select pin, active low (asynchronous)
- i_mosi  input  1  SPI master-out data pin (asynchronous)
- o_miso  output  1  SPI slave-out data
- i_tx_data  input  DATA_WIDTH  word to send next
- i_tx_valid  input  1  i_tx_data valid
- o_tx_ready  output  1  TX buffer empty; write accepted when valid & ready
- o_rx_data  output  DATA_WIDTH  last complete received word; held until the next word completes
- o_rx_valid  output  1  one-cycle strobe when o_rx_data updates
- o_tx_underrun  output  1  one-cycle strobe when a word load found the TX buffer empty
- o_busy  output  1  high while in ACTIVE

## Operation
- Synchronisers: SYNC_STAGES flops per pin. Reset values: sclk 0, ss_n 1, mosi 1. One extra registered copy of synced sclk and ss_n is used for edge detection (rise/fall strobes).
- TX buffer: single entry. A write when i_tx_valid & o_tx_ready captures i_tx_data and sets full (o_tx_ready=0). A word load empties the buffer.
- Word load: the tx shift reg takes the buffer contents if full, else all-ones with an o_tx_underrun pulse. A load and a write in the same cycle: the load sees the buffer as empty (no bypass), sends all-ones, pulses underrun; the write is captured for the next word.
- FSM IDLE: o_busy=0, o_miso=1. On a synced ss_n falling edge: word load, bit counter=0, go ACTIVE.
- FSM ACTIVE: o_miso = tx shift reg MSB.
  - sclk rise: rx shift reg <= {rx[DATA_WIDTH-2:0], mosi_sync}; counter++.
  - When the rise makes counter == DATA_WIDTH: next cycle o_rx_data <= completed word and o_rx_valid=1 for one cycle; counter wraps to 0 and a reload flag is set.
  - sclk fall: if the reload flag is set, do a word load and clear the flag; else tx reg <= {tx[DATA_WIDTH-2:0],1'b1}.
- ss_n rise (synced) in ACTIVE: return to IDLE at once. The partial rx word is discarded (no o_rx_valid, o_rx_data unchanged), the counter clears, and o_miso=1. A TX word already loaded is lost; the buffer is not refilled.
- ss_n falling and sclk edge in the same cycle: ss_n takes priority, and the sclk edge is ignored.
- Counter width: clog2(DATA_WIDTH)+1. It never exceeds DATA_WIDTH.

## Timing
- Reset: o_miso=1, o_tx_ready=1, o_rx_data=all-ones, o_rx_valid=0, o_tx_underrun=0, o_busy=0, FSM=IDLE, tx/rx shift regs all-ones.
- Pin-to-action latency: SYNC_STAGES+1 i_clk cycles from a pin transition to the state update. o_miso changes 1 cycle after that.
- The first MISO bit is valid SYNC_STAGES+2 cycles after the SS_n fall. The master must wait at least that long before the first SCLK rise.
- o_rx_valid asserts SYNC_STAGES+2 cycles after the final SCLK rise of a word.
- SCLK high and low phases must each be ≥ SYNC_STAGES+3 i_clk cycles. Faster SCLK is unsupported; behaviour is undefined.
- o_tx_ready rises the cycle after a load; a new write is accepted the same cycle it is high.
- For the next word to go out, the buffer must be written before the falling SCLK edge that follows the final rise.

## Test plan
- Reset mid-ACTIVE (i_rst low for 1 cycle) -> all outputs return to reset values at once; the next frame works normally.
- Write 0xA5; SS_n low; master sends 0x3C over 8 SCLKs -> MISO shows 1,0,1,0,0,1,0,1; o_rx_data=0x3C with one o_rx_valid pulse; o_tx_ready=1 after the load.
- Back-to-back: write 0x81, then 0x7E during word 1; master sends 0xF0,0x0F with SS_n held low -> MISO words 0x81,0x7E; two rx_valid pulses with 0xF0 then 0x0F.
- No TX write before SS_n falls -> one o_tx_underrun pulse; MISO all ones for the word; rx still correct.
- SS_n rises after 5 SCLKs -> no rx_valid; o_rx_data keeps its prior value; o_busy falls; the next full frame receives correctly.
- Write coincident with the load cycle -> underrun pulse; the written value goes out as the following word.
